// File: rtl/parking_system.sv
// Single-lane car park gate controller: entrance sensor, 7-field access code, LED and 7-segment status.
// Optional macro PARK_COUNT_EN adds a saturating admission counter that locks the entrance when full.
module parking_system #(
    parameter logic [3:0]  PASS1       = 4'd2,
    parameter logic [3:0]  PASS2       = 4'd6,
    parameter logic [7:0]  PASS3       = 8'd84,
    parameter logic [7:0]  PASS4       = 8'd65,
    parameter logic [3:0]  PASS5       = 4'd6,
    parameter logic [3:0]  PASS6       = 4'd6,
    parameter logic [3:0]  PASS7       = 4'd1,
    parameter int unsigned WAIT_CYCLES = 3,
    parameter int unsigned CAPACITY    = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sensor_entrance,
    input  logic       sensor_exit,
    input  logic [3:0] password_1,
    input  logic [3:0] password_2,
    input  logic [7:0] password_3,
    input  logic [7:0] password_4,
    input  logic [3:0] password_5,
    input  logic [3:0] password_6,
    input  logic [3:0] password_7,
    output logic       GREEN_LED,
    output logic       RED_LED,
    output logic [6:0] HEX_1,
    output logic [6:0] HEX_2
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PASSWORD,
        WRONG_PASS,
        RIGHT_PASS,
        STOP
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_CYCLES);

    // Segment patterns, active-low, {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_N     = 7'b0101011;
    localparam logic [6:0] SEG_G     = 7'b0000010;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_L     = 7'b1000111;

    state_t     state_reg, state_next;
    logic [7:0] wait_cnt_reg, wait_cnt_next;
    logic       green_next, red_next;
    logic       match;
    logic       full;

    assign match = (password_1 == PASS1) && (password_2 == PASS2) &&
                   (password_3 == PASS3) && (password_4 == PASS4) &&
                   (password_5 == PASS5) && (password_6 == PASS6) &&
                   (password_7 == PASS7);

`ifdef PARK_COUNT_EN
    localparam logic [7:0] CAP = 8'(CAPACITY);
    logic [7:0] park_count_reg;

    assign full = (park_count_reg == CAP);

    // Only a clean exit counts as an admission; a tailgate into STOP does not.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            park_count_reg <= 8'd0;
        end else if (state_reg == RIGHT_PASS && state_next == IDLE && !full) begin
            park_count_reg <= park_count_reg + 8'd1;
        end
    end
`else
    assign full = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 8'd0;
            GREEN_LED    <= 1'b0;
            RED_LED      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            GREEN_LED    <= green_next;
            RED_LED      <= red_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (sensor_entrance && !full) begin
                    state_next    = WAIT_PASSWORD;
                    wait_cnt_next = 8'd0;
                end
            end
            WAIT_PASSWORD: begin
                if (wait_cnt_reg < WAIT_LIMIT) begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end else if (match) begin
                    state_next = RIGHT_PASS;
                end else begin
                    state_next = WRONG_PASS;
                end
            end
            WRONG_PASS: begin
                if (match) state_next = RIGHT_PASS;
            end
            RIGHT_PASS: begin
                if (sensor_entrance && sensor_exit) state_next = STOP;
                else if (sensor_exit)               state_next = IDLE;
            end
            STOP: begin
                if (match) state_next = RIGHT_PASS;
            end
            default: state_next = IDLE;
        endcase
    end

    // LEDs follow the state being entered so they line up with the HEX text.
    always_comb begin
        green_next = 1'b0;
        red_next   = 1'b0;
        case (state_next)
            WAIT_PASSWORD: red_next   = 1'b1;
            WRONG_PASS:    red_next   = ~RED_LED;
            RIGHT_PASS:    green_next = ~GREEN_LED;
            STOP:          red_next   = ~RED_LED;
            default: begin
                green_next = 1'b0;
                red_next   = 1'b0;
            end
        endcase
    end

    always_comb begin
        HEX_1 = SEG_BLANK;
        HEX_2 = SEG_BLANK;
        case (state_reg)
            IDLE: begin
                if (full) begin
                    HEX_1 = SEG_F;
                    HEX_2 = SEG_L;
                end
            end
            WAIT_PASSWORD: begin
                HEX_1 = SEG_E;
                HEX_2 = SEG_N;
            end
            WRONG_PASS: begin
                HEX_1 = SEG_E;
                HEX_2 = SEG_E;
            end
            RIGHT_PASS: begin
                HEX_1 = SEG_G;
                HEX_2 = SEG_O;
            end
            STOP: begin
                HEX_1 = SEG_S;
                HEX_2 = SEG_P;
            end
            default: begin
                HEX_1 = SEG_BLANK;
                HEX_2 = SEG_BLANK;
            end
        endcase
    end

endmodule

// File: tb/tb_parking_system.sv
// Directed self-checking bench for parking_system; observes {GREEN_LED, RED_LED, HEX_1, HEX_2}.
module tb_parking_system;

    localparam logic [6:0] H_BL = 7'b1111111;
    localparam logic [6:0] H_E  = 7'b0000110;
    localparam logic [6:0] H_N  = 7'b0101011;
    localparam logic [6:0] H_G  = 7'b0000010;
    localparam logic [6:0] H_O  = 7'b1000000;
    localparam logic [6:0] H_S  = 7'b0010010;
    localparam logic [6:0] H_P  = 7'b0001100;
    localparam logic [6:0] H_F  = 7'b0001110;
    localparam logic [6:0] H_L  = 7'b1000111;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sensor_entrance, sensor_exit;
    logic [3:0] password_1, password_2, password_5, password_6, password_7;
    logic [7:0] password_3, password_4;
    logic       GREEN_LED, RED_LED;
    logic [6:0] HEX_1, HEX_2;

    logic [15:0] obs;
    logic [15:0] exp;
    int checks = 0;
    int failures = 0;

    assign obs = {GREEN_LED, RED_LED, HEX_1, HEX_2};

    always #5 clk = ~clk;

    parking_system #(.CAPACITY(2)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sensor_entrance(sensor_entrance),
        .sensor_exit(sensor_exit),
        .password_1(password_1),
        .password_2(password_2),
        .password_3(password_3),
        .password_4(password_4),
        .password_5(password_5),
        .password_6(password_6),
        .password_7(password_7),
        .GREEN_LED(GREEN_LED),
        .RED_LED(RED_LED),
        .HEX_1(HEX_1),
        .HEX_2(HEX_2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_code(input logic [3:0] p7);
        password_1 = 4'd2;
        password_2 = 4'd6;
        password_3 = 8'd84;
        password_4 = 8'd65;
        password_5 = 4'd6;
        password_6 = 4'd6;
        password_7 = p7;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        sensor_entrance = 1'b1;
        sensor_exit = 1'b0;
        set_code(4'd1);
        tick();
        tick();
        exp = {2'b00, H_BL, H_BL};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL reset_held: got %b want %b", obs, exp); end
        reset_n = 1'b1;
        #1;
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL reset_release: got %b want %b", obs, exp); end
        sensor_entrance = 1'b0;
        tick();
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL reset_idle: got %b want %b", obs, exp); end
    endtask

    task automatic test_correct_code();
        set_code(4'd1);
        sensor_entrance = 1'b1;
        tick();
        exp = {2'b01, H_E, H_N};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL correct_entry: got %b want %b", obs, exp); end
        sensor_entrance = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL correct_still_wait: got %b want %b", obs, exp); end
        tick();
        exp = {2'b10, H_G, H_O};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL correct_go1: got %b want %b", obs, exp); end
        tick();
        exp = {2'b00, H_G, H_O};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL correct_go0: got %b want %b", obs, exp); end
        tick();
        exp = {2'b10, H_G, H_O};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL correct_go1b: got %b want %b", obs, exp); end
    endtask

    task automatic test_exit();
        sensor_exit = 1'b1;
        tick();
        sensor_exit = 1'b0;
        exp = {2'b00, H_BL, H_BL};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL exit_idle: got %b want %b", obs, exp); end
    endtask

    task automatic test_wrong_code();
        set_code(4'd2);
        sensor_entrance = 1'b1;
        tick();
        sensor_entrance = 1'b0;
        repeat (4) tick();
        exp = {2'b00, H_E, H_E};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL wrong_enter: got %b want %b", obs, exp); end
        tick();
        exp = {2'b01, H_E, H_E};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL wrong_toggle1: got %b want %b", obs, exp); end
        tick();
        exp = {2'b00, H_E, H_E};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL wrong_toggle0: got %b want %b", obs, exp); end
        set_code(4'd1);
        tick();
        exp = {2'b10, H_G, H_O};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL wrong_to_right: got %b want %b", obs, exp); end
    endtask

    task automatic test_tailgate();
        set_code(4'd2);
        sensor_entrance = 1'b1;
        sensor_exit = 1'b1;
        tick();
        exp = {2'b01, H_S, H_P};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL tailgate_stop: got %b want %b", obs, exp); end
        sensor_entrance = 1'b0;
        sensor_exit = 1'b0;
        tick();
        exp = {2'b00, H_S, H_P};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL tailgate_hold: got %b want %b", obs, exp); end
        set_code(4'd1);
        tick();
        exp = {2'b10, H_G, H_O};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL tailgate_release: got %b want %b", obs, exp); end
    endtask

    task automatic test_async_reset();
        #3;
        reset_n = 1'b0;
        #1;
        exp = {2'b00, H_BL, H_BL};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL async_reset: got %b want %b", obs, exp); end
        #2;
        reset_n = 1'b1;
        tick();
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL async_reset_after: got %b want %b", obs, exp); end
    endtask

    task automatic test_late_code_change();
        set_code(4'd2);
        sensor_entrance = 1'b1;
        tick();
        sensor_entrance = 1'b0;
        tick();
        tick();
        set_code(4'd1);
        tick();
        exp = {2'b01, H_E, H_N};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL late_still_wait: got %b want %b", obs, exp); end
        tick();
        exp = {2'b10, H_G, H_O};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL late_eval: got %b want %b", obs, exp); end
        sensor_exit = 1'b1;
        tick();
        sensor_exit = 1'b0;
    endtask

`ifdef PARK_COUNT_EN
    task automatic admit_once();
        set_code(4'd1);
        sensor_entrance = 1'b1;
        tick();
        sensor_entrance = 1'b0;
        repeat (4) tick();
        sensor_exit = 1'b1;
        tick();
        sensor_exit = 1'b0;
    endtask

    task automatic test_capacity();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        admit_once();
        exp = {2'b00, H_BL, H_BL};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL cap_one: got %b want %b", obs, exp); end
        admit_once();
        exp = {2'b00, H_F, H_L};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL cap_full: got %b want %b", obs, exp); end
        sensor_entrance = 1'b1;
        tick();
        tick();
        sensor_entrance = 1'b0;
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL cap_blocked: got %b want %b", obs, exp); end
    endtask
`endif

    initial begin
        test_reset();
        test_correct_code();
        test_exit();
        test_wrong_code();
        test_tailgate();
        test_async_reset();
        test_late_code_change();
`ifdef PARK_COUNT_EN
        test_capacity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
